// File: rtl/lut_table_apply.sv
// lut_table_apply: remaps each component of an AXI4-Stream video pixel
// through a CSR-writable look-up table.
//
// Ports:
//   clk_i, rst_n_i               clock, asynchronous active-low reset
//   lut_orig_px_i, lut_mod_px_i  table write address / data (low PX_WIDTH bits used)
//   lut_wr_stb_i                 single-cycle table write strobe
//   s_t*                         input pixel stream (valid/ready/data/user/last)
//   m_t*                         remapped pixel stream, two-stage pipeline
module lut_table_apply #(
    parameter int PX_WIDTH = 10,
    parameter int COMP_CNT = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [31:0]                  lut_orig_px_i,
    input  logic [31:0]                  lut_mod_px_i,
    input  logic                         lut_wr_stb_i,
    input  logic                         s_tvalid_i,
    output logic                         s_tready_o,
    input  logic [PX_WIDTH*COMP_CNT-1:0] s_tdata_i,
    input  logic                         s_tuser_i,
    input  logic                         s_tlast_i,
    output logic                         m_tvalid_o,
    input  logic                         m_tready_i,
    output logic [PX_WIDTH*COMP_CNT-1:0] m_tdata_o,
    output logic                         m_tuser_o,
    output logic                         m_tlast_o
);

    localparam int DEPTH = 2 ** PX_WIDTH;
    localparam int DW    = PX_WIDTH * COMP_CNT;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t              state;
    logic [PX_WIDTH-1:0] init_cnt;

    logic                pend_v;
    logic [PX_WIDTH-1:0] pend_addr;
    logic [PX_WIDTH-1:0] pend_data;

    logic [PX_WIDTH-1:0] stb_addr;
    logic [PX_WIDTH-1:0] stb_data;

    logic                en;
    logic                we;
    logic [PX_WIDTH-1:0] wr_addr;
    logic [PX_WIDTH-1:0] wr_data;
    logic [DW-1:0]       rd_data;

    logic                v1;
    logic                u1;
    logic                l1;

    logic                unused_hi;

    assign stb_addr = lut_orig_px_i[PX_WIDTH-1:0];
    assign stb_data = lut_mod_px_i[PX_WIDTH-1:0];
    assign unused_hi = ^{lut_orig_px_i[31:PX_WIDTH],
                         lut_mod_px_i[31:PX_WIDTH]};

    // The whole pipeline advances together; a stalled output freezes both
    // stages including the RAM read port.
    assign en         = !m_tvalid_o || m_tready_i;
    assign s_tready_o = en && (state == RUN);

    // Single write port shared by identity fill, deferred and live strobes.
    always_comb begin
        we      = 1'b0;
        wr_addr = init_cnt;
        wr_data = init_cnt;
        if (state == INIT) begin
            we = 1'b1;
        end else if (pend_v) begin
            we      = 1'b1;
            wr_addr = pend_addr;
            wr_data = pend_data;
        end else if (lut_wr_stb_i) begin
            we      = 1'b1;
            wr_addr = stb_addr;
            wr_data = stb_data;
        end
    end

    // A strobe that cannot use the write port this cycle is parked in the
    // one-deep pending slot and applied on the next RUN cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= INIT;
            init_cnt  <= '0;
            pend_v    <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (&init_cnt) begin
                        state <= RUN;
                    end
                    if (lut_wr_stb_i) begin
                        pend_v    <= 1'b1;
                        pend_addr <= stb_addr;
                        pend_data <= stb_data;
                    end
                end
                RUN: begin
                    if (pend_v) begin
                        pend_v <= lut_wr_stb_i;
                        if (lut_wr_stb_i) begin
                            pend_addr <= stb_addr;
                            pend_data <= stb_data;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // One table copy per component, all written identically. Non-blocking
    // read and write in the same block give read-first behaviour.
    for (genvar k = 0; k < COMP_CNT; k++) begin : g_comp
        logic [PX_WIDTH-1:0] mem [DEPTH];
        logic [PX_WIDTH-1:0] rd_q;

        always_ff @(posedge clk_i) begin
            if (we) begin
                mem[wr_addr] <= wr_data;
            end
            if (en) begin
                rd_q <= mem[s_tdata_i[k*PX_WIDTH +: PX_WIDTH]];
            end
        end

        assign rd_data[k*PX_WIDTH +: PX_WIDTH] = rd_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v1         <= 1'b0;
            u1         <= 1'b0;
            l1         <= 1'b0;
            m_tvalid_o <= 1'b0;
            m_tdata_o  <= '0;
            m_tuser_o  <= 1'b0;
            m_tlast_o  <= 1'b0;
        end else if (en) begin
            v1         <= s_tvalid_i && s_tready_o;
            u1         <= s_tuser_i;
            l1         <= s_tlast_i;
            m_tvalid_o <= v1;
            m_tdata_o  <= rd_data;
            m_tuser_o  <= u1;
            m_tlast_o  <= l1;
        end
    end

endmodule

// File: tb/tb_lut_table_apply.sv
// tb_lut_table_apply: directed test of the pixel LUT stage against a
// table/queue reference model.
module tb_lut_table_apply;

    localparam int PXW   = 10;
    localparam int CC    = 3;
    localparam int DW    = PXW * CC;
    localparam int DEPTH = 1 << PXW;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic [31:0]   lut_orig_px_i = '0;
    logic [31:0]   lut_mod_px_i = '0;
    logic          lut_wr_stb_i = 1'b0;
    logic          s_tvalid_i = 1'b0;
    logic          s_tready_o;
    logic [DW-1:0] s_tdata_i = '0;
    logic          s_tuser_i = 1'b0;
    logic          s_tlast_i = 1'b0;
    logic          m_tvalid_o;
    logic          m_tready_i = 1'b1;
    logic [DW-1:0] m_tdata_o;
    logic          m_tuser_o;
    logic          m_tlast_o;

    lut_table_apply #(.PX_WIDTH(PXW), .COMP_CNT(CC)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .lut_orig_px_i(lut_orig_px_i),
        .lut_mod_px_i (lut_mod_px_i),
        .lut_wr_stb_i (lut_wr_stb_i),
        .s_tvalid_i   (s_tvalid_i),
        .s_tready_o   (s_tready_o),
        .s_tdata_i    (s_tdata_i),
        .s_tuser_i    (s_tuser_i),
        .s_tlast_i    (s_tlast_i),
        .m_tvalid_o   (m_tvalid_o),
        .m_tready_i   (m_tready_i),
        .m_tdata_o    (m_tdata_o),
        .m_tuser_o    (m_tuser_o),
        .m_tlast_o    (m_tlast_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
        logic [31:0]   acc;
    } exp_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
        logic [31:0]   acc;
        logic [31:0]   oc;
    } got_t;

    exp_t          exp_q[$];
    got_t          got_q[$];
    exp_t          e;

    int            total = 0;
    int            bad = 0;
    int            gcyc = 0;
    int            cyc = 0;
    logic          bp = 1'b0;

    logic [PXW-1:0] mtab [DEPTH];
    logic           pend_v = 1'b0;
    logic [PXW-1:0] pend_a = '0;
    logic [PXW-1:0] pend_d = '0;
    logic           hold_v = 1'b0;
    logic [DW+1:0]  hold_val = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [DW-1:0] map(input logic [DW-1:0] p);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < CC; k++) begin
            r[k*PXW +: PXW] = mtab[p[k*PXW +: PXW]];
        end
        return r;
    endfunction

    // Reference model and compare process, evaluated mid-cycle.
    always @(negedge clk_i) begin
        gcyc++;
        if (!rst_n_i) begin
            chk("rst_valid", 64'(m_tvalid_o), 64'd0);
            chk("rst_ready", 64'(s_tready_o), 64'd0);
            chk("rst_data", 64'(m_tdata_o), 64'd0);
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) begin
                mtab[i] = PXW'(i);
            end
            pend_v = 1'b0;
            hold_v = 1'b0;
            cyc = 0;
        end else begin
            if (cyc < DEPTH) begin
                chk("init_ready", 64'(s_tready_o), 64'd0);
            end else if (cyc == DEPTH && m_tready_i) begin
                chk("run_ready", 64'(s_tready_o), 64'd1);
            end
            if (m_tvalid_o) begin
                if (hold_v) begin
                    chk("hold_stable",
                        64'({m_tdata_o, m_tuser_o, m_tlast_o}),
                        64'(hold_val));
                end
                if (m_tready_i) begin
                    hold_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", 64'(m_tdata_o), 64'(e.d));
                        chk("out_user", 64'(m_tuser_o), 64'(e.u));
                        chk("out_last", 64'(m_tlast_o), 64'(e.l));
                        got_q.push_back({m_tdata_o, m_tuser_o, m_tlast_o,
                                         e.acc, 32'(gcyc)});
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_val = {m_tdata_o, m_tuser_o, m_tlast_o};
                end
            end else begin
                hold_v = 1'b0;
            end
            // Lookup sees the table before this cycle's write.
            if (s_tvalid_i && s_tready_o) begin
                exp_q.push_back({map(s_tdata_i), s_tuser_i, s_tlast_i,
                                 32'(gcyc)});
            end
            if (cyc >= DEPTH) begin
                if (pend_v) begin
                    mtab[pend_a] = pend_d;
                    pend_v = lut_wr_stb_i;
                    pend_a = lut_orig_px_i[PXW-1:0];
                    pend_d = lut_mod_px_i[PXW-1:0];
                end else if (lut_wr_stb_i) begin
                    mtab[lut_orig_px_i[PXW-1:0]] = lut_mod_px_i[PXW-1:0];
                end
            end else if (lut_wr_stb_i) begin
                pend_v = 1'b1;
                pend_a = lut_orig_px_i[PXW-1:0];
                pend_d = lut_mod_px_i[PXW-1:0];
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [31:0] oa, input logic [31:0] md);
        lut_wr_stb_i = 1'b1;
        lut_orig_px_i = oa;
        lut_mod_px_i = md;
        step();
        lut_wr_stb_i = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic u,
                        input logic l, input logic stb,
                        input logic [31:0] oa, input logic [31:0] md);
        logic acc;
        acc = 1'b0;
        s_tvalid_i = 1'b1;
        s_tdata_i = d;
        s_tuser_i = u;
        s_tlast_i = l;
        lut_wr_stb_i = stb;
        lut_orig_px_i = oa;
        lut_mod_px_i = md;
        for (int k = 0; k < 200 && !acc; k++) begin
            if (bp) m_tready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            acc = s_tready_o;
            @(posedge clk_i);
            #1;
            lut_wr_stb_i = 1'b0;
        end
        s_tvalid_i = 1'b0;
        if (!acc) chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        s_tvalid_i = 1'b0;
        while (exp_q.size() != 0 && n < 300) begin
            m_tready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        m_tready_i = 1'b1;
        step();
        step();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (n < 3000) begin
            @(negedge clk_i);
            if (s_tready_o) break;
            n++;
        end
        step();
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        s_tvalid_i = 1'b0;
        step();
        step();
        step();
        rst_n_i = 1'b1;
    endtask

    initial begin
        int n;
        logic [PXW-1:0] iv;

        // Reset release, identity table, latency.
        do_reset();
        wait_ready(n);
        chk("init_len", 64'(n), 64'd1024);
        got_q.delete();
        send({3{10'h000}}, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        send({3{10'h155}}, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        send({3{10'h3FF}}, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drain();
        chk("t1_cnt", 64'(got_q.size()), 64'd3);
        if (got_q.size() >= 3) begin
            chk("t1_px0", 64'(got_q[0].d), 64'(30'h0));
            chk("t1_px1", 64'(got_q[1].d), 64'({3{10'h155}}));
            chk("t1_px2", 64'(got_q[2].d), 64'({3{10'h3FF}}));
            chk("t1_lat", 64'(got_q[0].oc - got_q[0].acc), 64'd2);
        end

        // Strobe in RUN, upper address/data bits ignored.
        got_q.delete();
        wr(32'hFFFF_FC10, 32'hABCD_E3F0);
        send({10'h010, 10'h011, 10'h010}, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drain();
        chk("t2_cnt", 64'(got_q.size()), 64'd1);
        if (got_q.size() >= 1) begin
            chk("t2_px", 64'(got_q[0].d), 64'({10'h3F0, 10'h011, 10'h3F0}));
        end

        // Read/write collision: old value first, new value next.
        got_q.delete();
        send({3{10'h020}}, 1'b0, 1'b0, 1'b1, 32'h020, 32'h001);
        send({3{10'h020}}, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drain();
        chk("t3_cnt", 64'(got_q.size()), 64'd2);
        if (got_q.size() >= 2) begin
            chk("t3_old", 64'(got_q[0].d), 64'({3{10'h020}}));
            chk("t3_new", 64'(got_q[1].d), 64'({3{10'h001}}));
        end

        // Backpressure stream 0..99 on a restored identity table.
        wr(32'h010, 32'h010);
        wr(32'h020, 32'h020);
        got_q.delete();
        bp = 1'b1;
        for (int i = 0; i < 100; i++) begin
            iv = PXW'(i);
            send({3{iv}}, i == 0, i == 99, 1'b0, 32'd0, 32'd0);
        end
        drain();
        bp = 1'b0;
        chk("t4_cnt", 64'(got_q.size()), 64'd100);
        if (got_q.size() >= 100) begin
            for (int i = 0; i < 100; i++) begin
                iv = PXW'(i);
                chk("t4_px", 64'(got_q[i].d), 64'({3{iv}}));
            end
            chk("t4_user", 64'(got_q[0].u), 64'd1);
            chk("t4_last", 64'(got_q[99].l), 64'd1);
        end

        // Strobes during INIT: only the last one survives.
        do_reset();
        wr(32'd5, 32'd7);
        wr(32'd6, 32'd9);
        wait_ready(n);
        got_q.delete();
        send({10'd5, 10'd6, 10'd5}, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drain();
        chk("t5_cnt", 64'(got_q.size()), 64'd1);
        if (got_q.size() >= 1) begin
            chk("t5_px", 64'(got_q[0].d), 64'({10'd5, 10'd9, 10'd5}));
        end

        // Reset mid-frame drops in-flight pixels and CSR entries.
        got_q.delete();
        wr(32'd3, 32'h200);
        send({3{10'd3}}, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drain();
        chk("t6_cnt", 64'(got_q.size()), 64'd1);
        if (got_q.size() >= 1) begin
            chk("t6_mod", 64'(got_q[0].d), 64'({3{10'h200}}));
        end
        s_tvalid_i = 1'b1;
        s_tdata_i = {3{10'd1}};
        step();
        step();
        chk("t6_pre_valid", 64'(m_tvalid_o), 64'd1);
        rst_n_i = 1'b0;
        s_tvalid_i = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(m_tvalid_o), 64'd0);
        step();
        step();
        rst_n_i = 1'b1;
        wait_ready(n);
        chk("t6_init_len", 64'(n), 64'd1024);
        got_q.delete();
        send({3{10'd3}}, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drain();
        chk("t6_cnt2", 64'(got_q.size()), 64'd1);
        if (got_q.size() >= 1) begin
            chk("t6_ident", 64'(got_q[0].d), 64'({3{10'd3}}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
